sram_bus_arbiter: RTL

Shares one SRAM-like memory port between the instruction-fetch requester (pre-IF stage) and the data requester (EXE/MEM stage). Grants at most one address handshake per cycle and records the owner of every accepted request in an in-order tag FIFO. Uses that FIFO to route each downstream data response back to its requester. Sits between the CPU core's inst/data SRAM-like interfaces and the AXI bridge or memory model.

---
 rtl/sram_bus_arbiter_pkg.sv | 14 +
 rtl/sram_bus_arbiter_tag_fifo.sv | 50 +++++
 rtl/sram_bus_arbiter.sv | 119 +++++++++++
 3 files changed

// File: rtl/sram_bus_arbiter_pkg.sv
// Shared definitions for the SRAM-like bus arbiter: requester IDs and field widths.
package sram_bus_arbiter_pkg;

  typedef enum logic {
    OWNER_DATA = 1'b0,
    OWNER_INST = 1'b1
  } owner_e;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned SIZE_W = 2;
  localparam int unsigned STRB_W = 4;

endpackage

// File: rtl/sram_bus_arbiter_tag_fifo.sv
// In-order owner-tag FIFO: one bit per accepted request, popped per response.
module tag_fifo
  import sram_bus_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     push_owner,
  input  logic                     pop,
  output logic                     head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [DEPTH-1:0] tags;
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign head  = tags[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) tags[wr_ptr] <= push_owner;
  end

  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sram_bus_arbiter.sv
// Arbitrates inst/data SRAM-like requesters onto one memory port and routes
// in-order responses back using the owner tag FIFO.
module sram_bus_arbiter
  import sram_bus_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned STARVE_MAX = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inst_req,
  input  logic              inst_wr,
  input  logic [SIZE_W-1:0] inst_size,
  input  logic [STRB_W-1:0] inst_wstrb,
  input  logic [ADDR_W-1:0] inst_addr,
  input  logic [DATA_W-1:0] inst_wdata,
  output logic              inst_addr_ok,
  output logic              inst_data_ok,
  output logic [DATA_W-1:0] inst_rdata,
  input  logic              data_req,
  input  logic              data_wr,
  input  logic [SIZE_W-1:0] data_size,
  input  logic [STRB_W-1:0] data_wstrb,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_addr_ok,
  output logic              data_data_ok,
  output logic [DATA_W-1:0] data_rdata,
  output logic              mem_req,
  output logic              mem_wr,
  output logic [SIZE_W-1:0] mem_size,
  output logic [STRB_W-1:0] mem_wstrb,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_addr_ok,
  input  logic              mem_data_ok,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              proto_err
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned SW = $clog2(STARVE_MAX + 1);

  logic [CW-1:0] count;
  logic          full;
  logic          empty;
  logic          head;
  logic [SW-1:0] starve_cnt;
  logic          starve_hit;
  logic          sel_inst;
  logic          push;
  logic          pop;
  logic          inst_push;

  assign starve_hit = (starve_cnt == SW'(STARVE_MAX));
  assign sel_inst   = inst_req & (~data_req | starve_hit);
  assign mem_req    = (inst_req | data_req) & ~full;
  assign push       = mem_req & mem_addr_ok;
  assign inst_push  = push & sel_inst;
  assign pop        = mem_data_ok & ~empty;

  assign inst_addr_ok = inst_push;
  assign data_addr_ok = push & ~sel_inst;

  always_comb begin
    if (sel_inst) begin
      mem_wr    = inst_wr;
      mem_size  = inst_size;
      mem_wstrb = inst_wstrb;
      mem_addr  = inst_addr;
      mem_wdata = inst_wdata;
    end else begin
      mem_wr    = data_wr;
      mem_size  = data_size;
      mem_wstrb = data_wstrb;
      mem_addr  = data_addr;
      mem_wdata = data_wdata;
    end
  end

  assign inst_data_ok = pop & (head == OWNER_INST);
  assign data_data_ok = pop & (head == OWNER_DATA);
  assign inst_rdata   = inst_data_ok ? mem_rdata : '0;
  assign data_rdata   = data_data_ok ? mem_rdata : '0;

  tag_fifo #(
    .DEPTH(DEPTH)
  ) u_tag_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_owner(sel_inst ? OWNER_INST : OWNER_DATA),
    .pop       (pop),
    .head      (head),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (!inst_req || inst_push) begin
      starve_cnt <= '0;
    end else if (!starve_hit) begin
      starve_cnt <= starve_cnt + SW'(1);
    end
  end

  // A response with nothing outstanding means downstream lost sync; latch it.
  always_ff @(posedge clk) begin
    if (reset) begin
      proto_err <= 1'b0;
    end else if (mem_data_ok && count == '0) begin
      proto_err <= 1'b1;
    end
  end

endmodule
